// File: rtl/bank_eraser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bank_eraser_pkg
//  Purpose  : AXI4 encodings and small helpers shared by the bank eraser.
//  Revision : 1.0  initial release
// ============================================================================
package bank_eraser_pkg;

    // AXI burst type for incrementing bursts
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // AXI write response code for a successful write
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AWSIZE encoding: log2 of the number of bytes moved per beat
    function automatic logic [2:0] axi_size(input int unsigned bytes_per_beat);
        return 3'($clog2(bytes_per_beat));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bank_eraser.sv
`default_nettype none
// ============================================================================
//  Module   : bank_eraser
//  Purpose  : Fills one RAM bank with a fixed byte pattern using AXI4 write
//             bursts after an erase_ram strobe, then reports idle.
//             Independent blocks: controller FSM, AW issuer, W issuer,
//             outstanding tracker and B response counter.
//  Revision : 1.0  initial release
// ============================================================================
module bank_eraser
    import bank_eraser_pkg::*;
#(
    parameter int unsigned DATA_WBITS      = 512,
    parameter logic [63:0] BASE_ADDR       = 64'h0,
    parameter logic [63:0] BANK_SIZE       = 64'h4000_0000,
    parameter int unsigned BURST_BEATS     = 64,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter logic [7:0]  FILL_BYTE       = 8'hFF
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      erase_ram,
    output logic                      erase_idle,
    output logic                      erase_error,
    output logic [31:0]               bursts_done,
    output logic [63:0]               M_AXI_AWADDR,
    output logic [7:0]                M_AXI_AWLEN,
    output logic [2:0]                M_AXI_AWSIZE,
    output logic [1:0]                M_AXI_AWBURST,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WBITS-1:0]     M_AXI_WDATA,
    output logic [DATA_WBITS/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WLAST,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY
);

    localparam int unsigned STRB_W      = DATA_WBITS / 8;
    localparam logic [63:0] BURST_BYTES = 64'(BURST_BEATS) * 64'(STRB_W);
    localparam logic [63:0] NBURSTS     = BANK_SIZE / BURST_BYTES;
    localparam logic [31:0] LAST_BURST  = 32'(NBURSTS - 64'd1);
    localparam logic [7:0]  LAST_BEAT   = 8'(BURST_BEATS - 1);
    localparam logic [3:0]  MAX_OUT     = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t       state_q;
    logic         erase_idle_q;

    logic         aw_valid_q;
    logic [63:0]  aw_addr_q;
    logic [31:0]  aw_count_q;

    logic [3:0]   out_q;
    logic [3:0]   out_d;

    logic         w_valid_q;
    logic [7:0]   w_beat_q;
    logic [4:0]   w_credit_q;
    logic [4:0]   w_credit_d;

    logic [31:0]  b_count_q;
    logic         b_error_q;

    logic         start;
    logic         aw_hs;
    logic         w_hs;
    logic         w_last_hs;
    logic         b_hs;

    assign start     = (state_q == ST_IDLE) && erase_ram;
    assign aw_hs     = aw_valid_q && M_AXI_AWREADY;
    assign w_hs      = w_valid_q && M_AXI_WREADY;
    assign w_last_hs = w_hs && (w_beat_q == LAST_BEAT);
    // Responses arriving while idle belong to nothing of ours and are not counted
    assign b_hs      = M_AXI_BVALID && (state_q != ST_IDLE);

    // Next-state values for in-flight bookkeeping; a same-cycle increment and
    // decrement cancel, and new AW credit is visible to the W issuer at once
    assign out_d      = out_q + {3'b000, aw_hs} - {3'b000, b_hs};
    assign w_credit_d = w_credit_q + {4'b0000, aw_hs} - {4'b0000, w_last_hs};

    // Controller FSM: IDLE -> RUN on strobe, RUN -> DRAIN after last AW, DRAIN -> IDLE after last B
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            erase_idle_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (erase_ram) begin
                        state_q      <= ST_RUN;
                        erase_idle_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (aw_hs && (aw_count_q == LAST_BURST)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (b_hs && (b_count_q == LAST_BURST)) begin
                        state_q      <= ST_IDLE;
                        erase_idle_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    erase_idle_q <= 1'b1;
                end
            endcase
        end
    end

    // AW issuer: one address per burst, held until accepted, throttled by outstanding count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_valid_q <= 1'b0;
            aw_addr_q  <= BASE_ADDR;
            aw_count_q <= 32'd0;
        end else if (start) begin
            aw_valid_q <= 1'b0;
            aw_addr_q  <= BASE_ADDR;
            aw_count_q <= 32'd0;
        end else if (state_q == ST_RUN) begin
            if (aw_hs) begin
                aw_addr_q  <= aw_addr_q + BURST_BYTES;
                aw_count_q <= aw_count_q + 32'd1;
                aw_valid_q <= (aw_count_q != LAST_BURST) && (out_d < MAX_OUT);
            end else if (!aw_valid_q) begin
                // RUN guarantees at least one burst is still unissued here
                aw_valid_q <= (out_d < MAX_OUT);
            end
        end else begin
            aw_valid_q <= 1'b0;
        end
    end

    // Outstanding tracker: accepted addresses minus received responses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q <= 4'd0;
        end else if (start) begin
            out_q <= 4'd0;
        end else begin
            out_q <= out_d;
        end
    end

    // W issuer: streams beats only for bursts whose address was accepted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_valid_q  <= 1'b0;
            w_beat_q   <= 8'd0;
            w_credit_q <= 5'd0;
        end else if (start) begin
            w_valid_q  <= 1'b0;
            w_beat_q   <= 8'd0;
            w_credit_q <= 5'd0;
        end else begin
            w_credit_q <= w_credit_d;
            if (w_hs) begin
                w_beat_q <= w_last_hs ? 8'd0 : (w_beat_q + 8'd1);
            end
            // A presented beat stays up until taken; otherwise offer one while credit remains
            if (!w_valid_q || M_AXI_WREADY) begin
                w_valid_q <= (w_credit_d != 5'd0);
            end
        end
    end

    // B counter: counts responses and latches any non-OKAY status for this pass
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            b_count_q <= 32'd0;
            b_error_q <= 1'b0;
        end else if (start) begin
            b_count_q <= 32'd0;
            b_error_q <= 1'b0;
        end else if (b_hs) begin
            b_count_q <= b_count_q + 32'd1;
            if (M_AXI_BRESP != AXI_RESP_OKAY) begin
                b_error_q <= 1'b1;
            end
        end
    end

    assign erase_idle    = erase_idle_q;
    assign erase_error   = b_error_q;
    assign bursts_done   = b_count_q;

    assign M_AXI_AWADDR  = aw_addr_q;
    assign M_AXI_AWLEN   = LAST_BEAT;
    assign M_AXI_AWSIZE  = axi_size(STRB_W);
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_AWVALID = aw_valid_q;

    assign M_AXI_WDATA   = {STRB_W{FILL_BYTE}};
    assign M_AXI_WSTRB   = {STRB_W{1'b1}};
    assign M_AXI_WLAST   = (w_beat_q == LAST_BEAT);
    assign M_AXI_WVALID  = w_valid_q;

    assign M_AXI_BREADY  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_bank_eraser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bank_eraser
//  Purpose  : Self-checking bench for bank_eraser with an AXI write-slave
//             model and an expected-address scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bank_eraser;

    localparam int          DW    = 512;
    localparam int          SW    = DW / 8;
    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] BSIZE = 64'd16384;
    localparam int          BEATS = 4;
    localparam int          MAXO  = 8;
    localparam int          NB    = 64;
    localparam logic [63:0] BBYTES = 64'd256;

    logic           clk = 1'b0;
    logic           resetn = 1'b1;
    logic           erase_ram = 1'b0;
    logic           erase_idle;
    logic           erase_error;
    logic [31:0]    bursts_done;
    logic [63:0]    awaddr;
    logic [7:0]     awlen;
    logic [2:0]     awsize;
    logic [1:0]     awburst;
    logic           awvalid;
    logic           awready = 1'b1;
    logic [DW-1:0]  wdata;
    logic [SW-1:0]  wstrb;
    logic           wlast;
    logic           wvalid;
    logic           wready = 1'b1;
    logic [1:0]     bresp = 2'b00;
    logic           bvalid = 1'b0;
    logic           bready;

    always #5 clk = ~clk;

    bank_eraser #(
        .DATA_WBITS      (DW),
        .BASE_ADDR       (BASE),
        .BANK_SIZE       (BSIZE),
        .BURST_BEATS     (BEATS),
        .MAX_OUTSTANDING (MAXO),
        .FILL_BYTE       (8'hFF)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .erase_ram     (erase_ram),
        .erase_idle    (erase_idle),
        .erase_error   (erase_error),
        .bursts_done   (bursts_done),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWLEN   (awlen),
        .M_AXI_AWSIZE  (awsize),
        .M_AXI_AWBURST (awburst),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WLAST   (wlast),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    logic [63:0]  exp_addr_q[$];
    int           aw_total = 0;
    int           w_total = 0;
    int           b_total = 0;
    int           tb_beat = 0;
    int           pend_b = 0;
    bit           rnd_aw = 1'b0;
    bit           rnd_w = 1'b0;
    bit           rnd_b = 1'b0;
    int           stall_after = 0;
    int           stall_len = 0;
    int           stall_cnt = 0;
    int           b_hold = 0;
    int           err_burst = -1;
    bit           prev_aw_wait = 1'b0;
    bit           prev_w_wait = 1'b0;
    logic [63:0]  prev_addr = 64'd0;
    logic         prev_wlast = 1'b0;
    logic [DW-1:0] fill_pat = {SW{8'hFF}};

    // Monitor: sees the values that the next rising edge will sample
    always @(negedge clk) begin
        if (!resetn) begin
            prev_aw_wait = 1'b0;
            prev_w_wait  = 1'b0;
        end else begin
            if (prev_aw_wait) begin
                n_checks++;
                if (awvalid !== 1'b1 || awaddr !== prev_addr) begin
                    n_errors++;
                    $display("FAIL aw_stable: valid=%b addr=%h, required valid=1 addr=%h", awvalid, awaddr, prev_addr);
                end
            end
            if (prev_w_wait) begin
                n_checks++;
                if (wvalid !== 1'b1 || wlast !== prev_wlast) begin
                    n_errors++;
                    $display("FAIL w_stable: valid=%b last=%b, required valid=1 last=%b", wvalid, wlast, prev_wlast);
                end
            end
            if (awvalid === 1'b1 && awready === 1'b1) begin
                n_checks++;
                if (exp_addr_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL aw_extra: addr=%h issued, required no further AW", awaddr);
                end else begin
                    logic [63:0] e;
                    e = exp_addr_q.pop_front();
                    if (awaddr !== e || awlen !== 8'd3 || awsize !== 3'd6 || awburst !== 2'b01) begin
                        n_errors++;
                        $display("FAIL aw_fields: addr=%h len=%0d size=%0d burst=%b, required addr=%h len=3 size=6 burst=01",
                                 awaddr, awlen, awsize, awburst, e);
                    end
                end
                aw_total++;
                if (stall_after > 0 && aw_total == stall_after) stall_cnt = stall_len;
            end
            if (wvalid === 1'b1 && wready === 1'b1) begin
                n_checks++;
                if (wdata !== fill_pat || wstrb !== {SW{1'b1}} || wlast !== (tb_beat == BEATS - 1)) begin
                    n_errors++;
                    $display("FAIL w_beat: beat=%0d last=%b strb_ok=%b data_ok=%b, required last=%b strb_ok=1 data_ok=1",
                             tb_beat, wlast, wstrb === {SW{1'b1}}, wdata === fill_pat, tb_beat == BEATS - 1);
                end
                w_total++;
                if (tb_beat == BEATS - 1) begin
                    tb_beat = 0;
                    pend_b++;
                end else begin
                    tb_beat++;
                end
            end
            if (bvalid === 1'b1) begin
                n_checks++;
                if (bready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL bready: bready=%b, required 1", bready);
                end
                b_total++;
                pend_b--;
            end
            n_checks++;
            if (w_total > BEATS * aw_total || aw_total - b_total > MAXO) begin
                n_errors++;
                $display("FAIL inflight: aw=%0d w=%0d b=%0d, required w<=%0d and outstanding<=%0d",
                         aw_total, w_total, b_total, BEATS * aw_total, MAXO);
            end
            prev_aw_wait = (awvalid === 1'b1) && (awready !== 1'b1);
            prev_addr    = awaddr;
            prev_w_wait  = (wvalid === 1'b1) && (wready !== 1'b1);
            prev_wlast   = wlast;
        end
    end

    // Slave model: drives ready and response signals just after each rising edge
    always @(posedge clk) begin
        #1;
        if (stall_cnt > 0) begin
            awready = 1'b0;
            stall_cnt--;
        end else begin
            awready = rnd_aw ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        wready = rnd_w ? 1'($urandom_range(0, 1)) : 1'b1;
        if (b_hold > 0) begin
            b_hold--;
            bvalid = 1'b0;
            bresp  = 2'b00;
        end else if (pend_b > 0 && (!rnd_b || $urandom_range(0, 1) == 1)) begin
            bvalid = 1'b1;
            bresp  = (b_total == err_burst) ? 2'b10 : 2'b00;
        end else begin
            bvalid = 1'b0;
            bresp  = 2'b00;
        end
    end

    task automatic start_pass();
        aw_total = 0;
        w_total  = 0;
        b_total  = 0;
        tb_beat  = 0;
        exp_addr_q.delete();
        for (int k = 0; k < NB; k++) exp_addr_q.push_back(BASE + BBYTES * 64'(k));
        @(posedge clk); #1 erase_ram = 1'b1;
        @(posedge clk); #1 erase_ram = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (erase_idle === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL wait_idle: erase_idle=%b after %0d cycles, required 1", erase_idle, budget);
        end
    endtask

    task automatic test_reset();
        #1 resetn = 1'b0;
        #1;
        n_checks++;
        if (erase_idle !== 1'b1 || erase_error !== 1'b0 || bursts_done !== 32'd0 ||
            awvalid !== 1'b0 || wvalid !== 1'b0 || awaddr !== BASE) begin
            n_errors++;
            $display("FAIL reset_state: idle=%b err=%b done=%0d awv=%b wv=%b addr=%h, required 1/0/0/0/0/%h",
                     erase_idle, erase_error, bursts_done, awvalid, wvalid, awaddr, BASE);
        end
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (erase_idle !== 1'b1 || awvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_hold: idle=%b awv=%b, required 1/0", erase_idle, awvalid);
        end
    endtask

    task automatic test_full_rate();
        start_pass();
        n_checks++;
        if (erase_idle !== 1'b0 || bursts_done !== 32'd0) begin
            n_errors++;
            $display("FAIL t1_start: idle=%b done=%0d, required 0/0", erase_idle, bursts_done);
        end
        wait_idle(1000);
        n_checks++;
        if (erase_idle !== 1'b1 || bursts_done !== 32'd64 || erase_error !== 1'b0 ||
            aw_total != NB || w_total != NB * BEATS || b_total != NB || exp_addr_q.size() != 0) begin
            n_errors++;
            $display("FAIL t1_end: idle=%b done=%0d err=%b aw=%0d w=%0d b=%0d left=%0d, required 1/64/0/64/256/64/0",
                     erase_idle, bursts_done, erase_error, aw_total, w_total, b_total, exp_addr_q.size());
        end
    endtask

    task automatic test_aw_stall();
        bit seen = 1'b0;
        stall_after = 3;
        stall_len   = 10;
        start_pass();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (stall_cnt > 0) begin
                seen = 1'b1;
                break;
            end
        end
        stall_after = 0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (!seen || awvalid !== 1'b1 || awaddr !== BASE + 64'd768 || aw_total != 3 || w_total > 12) begin
            n_errors++;
            $display("FAIL t2_stall: seen=%b awv=%b addr=%h aw=%0d w=%0d, required 1/1/%h/3/<=12",
                     seen, awvalid, awaddr, aw_total, w_total, BASE + 64'd768);
        end
        wait_idle(1000);
        n_checks++;
        if (bursts_done !== 32'd64 || erase_error !== 1'b0 || aw_total != NB || w_total != NB * BEATS ||
            exp_addr_q.size() != 0) begin
            n_errors++;
            $display("FAIL t2_end: done=%0d err=%b aw=%0d w=%0d left=%0d, required 64/0/64/256/0",
                     bursts_done, erase_error, aw_total, w_total, exp_addr_q.size());
        end
    endtask

    task automatic test_b_hold();
        b_hold = 50;
        start_pass();
        repeat (30) @(negedge clk);
        n_checks++;
        if (aw_total != MAXO || b_total != 0 || awvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL t3_limit: aw=%0d b=%0d awv=%b, required 8/0/0", aw_total, b_total, awvalid);
        end
        wait_idle(1000);
        n_checks++;
        if (bursts_done !== 32'd64 || erase_error !== 1'b0 || aw_total != NB || w_total != NB * BEATS ||
            exp_addr_q.size() != 0) begin
            n_errors++;
            $display("FAIL t3_end: done=%0d err=%b aw=%0d w=%0d left=%0d, required 64/0/64/256/0",
                     bursts_done, erase_error, aw_total, w_total, exp_addr_q.size());
        end
    endtask

    task automatic test_random();
        rnd_aw = 1'b1;
        rnd_w  = 1'b1;
        rnd_b  = 1'b1;
        for (int p = 0; p < 4; p++) begin
            start_pass();
            wait_idle(4000);
            n_checks++;
            if (bursts_done !== 32'd64 || erase_error !== 1'b0 || aw_total != NB || w_total != NB * BEATS ||
                b_total != NB || exp_addr_q.size() != 0) begin
                n_errors++;
                $display("FAIL t4_pass%0d: done=%0d err=%b aw=%0d w=%0d b=%0d left=%0d, required 64/0/64/256/64/0",
                         p, bursts_done, erase_error, aw_total, w_total, b_total, exp_addr_q.size());
            end
        end
        rnd_aw = 1'b0;
        rnd_w  = 1'b0;
        rnd_b  = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_slverr();
        err_burst = 17;
        start_pass();
        wait_idle(1000);
        err_burst = -1;
        n_checks++;
        if (erase_error !== 1'b1 || bursts_done !== 32'd64 || erase_idle !== 1'b1) begin
            n_errors++;
            $display("FAIL t5_err: err=%b done=%0d idle=%b, required 1/64/1", erase_error, bursts_done, erase_idle);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (erase_error !== 1'b1 || bursts_done !== 32'd64) begin
            n_errors++;
            $display("FAIL t5_hold: err=%b done=%0d, required 1/64", erase_error, bursts_done);
        end
        start_pass();
        n_checks++;
        if (erase_error !== 1'b0 || bursts_done !== 32'd0 || erase_idle !== 1'b0) begin
            n_errors++;
            $display("FAIL t5_clear: err=%b done=%0d idle=%b, required 0/0/0", erase_error, bursts_done, erase_idle);
        end
        wait_idle(1000);
        n_checks++;
        if (erase_error !== 1'b0 || bursts_done !== 32'd64 || exp_addr_q.size() != 0) begin
            n_errors++;
            $display("FAIL t5_clean: err=%b done=%0d left=%0d, required 0/64/0", erase_error, bursts_done, exp_addr_q.size());
        end
    endtask

    task automatic test_reset_midpass();
        bit reached = 1'b0;
        start_pass();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (b_total >= 30) begin
                reached = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (!reached || erase_idle !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0 ||
            bursts_done !== 32'd0 || awaddr !== BASE) begin
            n_errors++;
            $display("FAIL t6_reset: reached=%b idle=%b awv=%b wv=%b done=%0d addr=%h, required 1/1/0/0/0/%h",
                     reached, erase_idle, awvalid, wvalid, bursts_done, awaddr, BASE);
        end
        pend_b = 0;
        tb_beat = 0;
        exp_addr_q.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        start_pass();
        repeat (20) @(posedge clk);
        #1 erase_ram = 1'b1;
        @(posedge clk);
        #1 erase_ram = 1'b0;
        @(negedge clk);
        n_checks++;
        if (erase_idle !== 1'b0) begin
            n_errors++;
            $display("FAIL t6_midstrobe: idle=%b, required 0", erase_idle);
        end
        wait_idle(1000);
        n_checks++;
        if (bursts_done !== 32'd64 || erase_error !== 1'b0 || aw_total != NB || w_total != NB * BEATS ||
            exp_addr_q.size() != 0) begin
            n_errors++;
            $display("FAIL t6_end: done=%0d err=%b aw=%0d w=%0d left=%0d, required 64/0/64/256/0",
                     bursts_done, erase_error, aw_total, w_total, exp_addr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_aw_stall();
        test_b_hold();
        test_random();
        test_slverr();
        test_reset_midpass();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
